// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line and byte-output bundle of the UART receiver
//  din        serial input, idle high (driven by the line side)
//  data_rx    last correctly framed byte
//  valid      one-cycle strobe, data_rx updated
//  frame_err  one-cycle strobe, stop bit sampled 0
//  busy       receiver not idle
//  master: line source / byte consumer side; slave: the receiver itself
interface uart_receiver_if;
    logic       din;
    logic [7:0] data_rx;
    logic       valid;
    logic       frame_err;
    logic       busy;
    modport master (output din, input data_rx, valid, frame_err, busy);
    modport slave  (input din, output data_rx, valid, frame_err, busy);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver with mid-bit sampling and framing-error flag
//  clk   system clock, all logic on posedge
//  rst   synchronous reset, active-low
//  rx    uart_receiver_if.slave: din in; data_rx, valid, frame_err, busy out
module uart_receiver #(
    parameter int CLKS_PER_BIT = 279,
    parameter int HALF_BIT     = 139
) (
    input logic             clk,
    input logic             rst,
    uart_receiver_if.slave  rx
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam logic [8:0] LAST  = 9'(CLKS_PER_BIT - 1);
    localparam logic [8:0] MID   = 9'(HALF_BIT);

    logic [1:0] state;
    logic [8:0] cnt;
    logic [2:0] idx;
    logic [7:0] sh;
    logic       din_m, din_s, din_q;

    assign rx.busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            sh           <= '0;
            din_m        <= 1'b1;
            din_s        <= 1'b1;
            din_q        <= 1'b1;
            rx.data_rx   <= '0;
            rx.valid     <= 1'b0;
            rx.frame_err <= 1'b0;
        end else begin
            din_m        <= rx.din;
            din_s        <= din_m;
            din_q        <= din_s;
            rx.valid     <= 1'b0;
            rx.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // only a genuine 1->0 transition starts a frame, never a held-low line
                    if (din_q && !din_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == MID) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= din_s ? IDLE : DATA;
                    end else
                        cnt <= cnt + 9'd1;
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        sh[idx] <= din_s;
                        idx     <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end else
                        cnt <= cnt + 9'd1;
                end
                default: begin
                    // leave at mid stop bit so a back-to-back start edge is not missed
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (din_s) begin
                            rx.data_rx <= sh;
                            rx.valid   <= 1'b1;
                        end else
                            rx.frame_err <= 1'b1;
                    end else
                        cnt <= cnt + 9'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver with directed serial frames
module tb_uart_receiver;
    localparam int CPB = 279;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_strobes = 0;
    logic prev_strobe = 1'b0;
    exp_t q[$];

    uart_receiver_if u_if ();

    uart_receiver #(.CLKS_PER_BIT(CPB), .HALF_BIT(CPB / 2)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_strobe(input logic err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        q.push_back(e);
        n_pushed++;
    endtask

    task automatic drive_bit(input logic b);
        u_if.din = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    // behavioural stand-in for the team transmitter in loopback: en pulse loads data_tx
    task automatic tx_loopback(input logic [7:0] data_tx);
        send_frame(data_tx, 1'b1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d strobes outstanding after %0d cycles, required 0", name, q.size(), n);
            q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_data"}, u_if.data_rx, 8'h00);
        check({name, "_valid"}, {7'd0, u_if.valid}, 8'h00);
        check({name, "_ferr"}, {7'd0, u_if.frame_err}, 8'h00);
        check({name, "_busy"}, {7'd0, u_if.busy}, 8'h00);
    endtask

    // monitor: every strobe is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (rst && (u_if.valid || u_if.frame_err)) begin
            exp_t e;
            n_strobes++;
            check("strobe_exclusive", {7'd0, u_if.valid & u_if.frame_err}, 8'h00);
            check("strobe_single_cycle", {7'd0, prev_strobe}, 8'h00);
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: valid=%b frame_err=%b data_rx=%h, required none",
                         u_if.valid, u_if.frame_err, u_if.data_rx);
            end else begin
                e = q.pop_front();
                check("strobe_kind", {7'd0, u_if.frame_err}, {7'd0, e.err});
                check("strobe_data_rx", u_if.data_rx, e.data);
            end
        end
        prev_strobe = rst && (u_if.valid || u_if.frame_err);
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.din = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // T1: clean frame
        expect_strobe(1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("t1_a5", 2 * CPB);
        repeat (CPB) @(negedge clk);

        // T2: glitch shorter than half a bit aborts at the start mid-sample
        u_if.din = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_busy_start", {7'd0, u_if.busy}, 8'h01);
        repeat (40) @(negedge clk);
        u_if.din = 1'b1;
        repeat (200) @(negedge clk);
        check("t2_busy_idle", {7'd0, u_if.busy}, 8'h00);
        check("t2_data_kept", u_if.data_rx, 8'hA5);

        // T3: bad stop bit, line then held low
        expect_strobe(1'b1, 8'hA5);
        send_frame(8'h3C, 1'b0);
        wait_drain("t3_ferr", 2 * CPB);
        repeat (3000) @(negedge clk);
        check("t3_low_no_start", {7'd0, u_if.busy}, 8'h00);
        check("t3_data_kept", u_if.data_rx, 8'hA5);
        u_if.din = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // T4: back-to-back frames
        expect_strobe(1'b0, 8'h00);
        expect_strobe(1'b0, 8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("t4_b2b", 2 * CPB);
        check("t4_last_data", u_if.data_rx, 8'hFF);
        repeat (CPB) @(negedge clk);

        // T5: reset mid-DATA of 0x55 drops the byte; line then idles high
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        repeat (CPB / 2) @(negedge clk);
        check("t5_busy_before", {7'd0, u_if.busy}, 8'h01);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        rst = 1'b1;
        u_if.din = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("t5_busy_after", {7'd0, u_if.busy}, 8'h00);
        expect_strobe(1'b0, 8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("t5_81", 2 * CPB);
        repeat (CPB) @(negedge clk);

        // T6: transmitter loopback
        expect_strobe(1'b0, 8'hC3);
        tx_loopback(8'hC3);
        wait_drain("t6_c3", 2 * CPB);
        repeat (2 * CPB) @(negedge clk);

        n_checks++;
        if (n_strobes != n_pushed) begin
            n_fail++;
            $display("FAIL strobe_count: got %0d, required %0d", n_strobes, n_pushed);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
